dma_issue_arbiter: RTL and testbench
====================================

// Module: dma_issue_arbiter
// PURPOSE
//  Shares one DMA backend and its transfer-ID space between NUM_REQ cluster-frontend requesters.
//  - Picks one pending request per cycle (round-robin) and stamps it with the next transfer ID.
//  - Limits in-flight transfers to MAX_OUTSTANDING.
//  - Routes in-order backend completions back to the originating requester.
//  Sits between the per-core register frontends and the DMA backend.
// PARAMETERS
//  NUM_REQ          4   number of requesters (>=2)
//  ID_WIDTH         16  transfer-ID width; ID 0 reserved as "none"
//  MAX_OUTSTANDING  8   max in-flight transfers (>=1); sets the tracker FIFO depth
// PORTS
//  clk_i          in   1                 clock
//  rst_ni         in   1                 reset, asynchronous, active-low
//  req_valid_i    in   NUM_REQ           requester i has a transfer pending
//  req_ready_o    out  NUM_REQ           one-hot; requester i is accepted this cycle
//  req_id_o       out  ID_WIDTH          ID given to the accepted request (valid with req_ready_o)
//  be_valid_o     out  1                 transfer offered to backend
//  be_ready_i     in   1                 backend accepts
//  be_src_o       out  $clog2(NUM_REQ)   index of the granted requester
//  be_done_i      in   1                 backend retires oldest transfer (in order)
//  done_valid_o   out  1                 completion pulse to requesters
//  done_src_o     out  $clog2(NUM_REQ)   requester owning the completed transfer
//  done_id_o      out  ID_WIDTH          ID of the completed transfer
//  next_id_o      out  ID_WIDTH          ID the next issue will receive
//  completed_id_o out  ID_WIDTH          last completed ID
//  outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight count
//  idle_o         out  1                 outstanding_o == 0
// BEHAVIOUR
//  Reset values:
//  - next_id = 1, completed_id = 0, outstanding = 0, RR pointer = 0, idle_o = 1.
//  - done_valid_o, done_src_o and done_id_o are 0; the tracker FIFO is empty.
//  Issue path (combinational, no bubble):
//  - full = (outstanding == MAX_OUTSTANDING).
//  - grant = first requester with req_valid_i set, searching from the RR pointer upward (wrap).
//  - be_valid_o = |req_valid_i & !full.
//  - be_src_o = grant index.
//  - req_ready_o[grant] = be_valid_o & be_ready_i.
//  - req_id_o = next_id.
//  Issue event (be_valid_o & be_ready_i):
//  - next_id advances by 1; the wrap goes 2^ID_WIDTH-1 -> 1, never 0.
//  - The grant index is pushed into the tracker FIFO.
//  - The RR pointer becomes grant+1 mod NUM_REQ. The pointer holds when nothing issues.
//  Retire event (be_done_i with FIFO non-empty):
//  - The oldest entry is popped and completed_id advances with the same wrap rule.
//  - Next cycle, done_valid_o=1 for one cycle, with done_src_o = popped index and done_id_o = the new completed_id.
//  Boundary cases:
//  - Full: no grant, be_valid_o=0, regardless of a retire in the same cycle; the freed slot is usable next cycle.
//  - Issue and retire in the same cycle: both happen, outstanding unchanged.
//  - be_done_i while empty: ignored, no state change; an assertion fires in simulation.
//  - be_valid_o may drop without handshake if requesters withdraw; the backend must not rely on valid stability.
//  - Async reset mid-transfer: all state clears; in-flight completions after reset are treated as while-empty.
// CONFIGURATION
//  DMA_ARB_PRIO_EN defined:
//  - Adds input prio_i [NUM_REQ].
//  - If any req_valid_i & prio_i is set, round-robin runs only over that subset; otherwise over all.
//  - The RR pointer is shared by both subsets.
//  DMA_ARB_PRIO_EN undefined: no prio_i port; pure round-robin.
// STRUCTURE
//  - Package dma_arb_pkg: ID_NONE='0; function next_id(id) implementing the skip-zero wrap.
//  - Sub-module dma_arb_rr: combinational round-robin picker (req vector + pointer -> one-hot grant + index).
//  - Tracker: common-cells fifo_v3, DEPTH=MAX_OUTSTANDING, DATA_WIDTH=$clog2(NUM_REQ).
// TESTING
//  1. Reset, no stimulus -> next_id_o=1, completed_id_o=0, idle_o=1, be_valid_o=0.
//  2. All 4 req_valid_i held, be_ready_i=1, 4 cycles -> grants 0,1,2,3, req_id_o 1,2,3,4, outstanding_o=4.
//  3. MAX_OUTSTANDING=8 transfers issued, be_ready_i=1 -> be_valid_o=0.
//     Then be_done_i for 1 cycle -> done_src_o=first src, done_id_o=1; be_valid_o=1 one cycle after the retire.
//  4. Issue and be_done_i in the same cycle at outstanding=3 -> outstanding_o stays 3, both IDs advance.
//  5. ID_WIDTH=2, 5 issues with retires -> req_id_o sequence 1,2,3,1,2; completed_id_o never 0 after the first retire.
//  6. DMA_ARB_PRIO_EN: req 0..3 valid, prio_i=4'b1000 -> requester 3 granted on every issue until prio drops.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared definitions for the DMA issue arbiter: the reserved "no transfer"
// ID and the skip-zero increment used for both issued and completed IDs.
package dma_arb_pkg;

  localparam int unsigned ID_MAX_WIDTH = 32;
  localparam logic [ID_MAX_WIDTH-1:0] ID_NONE = '0;

  // Increment an ID of the given width; the largest value wraps to 1 so that
  // ID_NONE is never handed out. Supports widths up to ID_MAX_WIDTH.
  function automatic logic [31:0] next_id(input logic [31:0] id, input int unsigned width);
    logic [32:0] top_id;
    top_id = (33'd1 << width) - 33'd1;
    if ({1'b0, id} >= top_id) begin
      return 32'd1;
    end
    return id + 32'd1;
  endfunction

endpackage

// File: rtl/dma_arb_rr.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping around. Produces a one-hot grant and its index.
module dma_arb_rr #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // Scan NUM_REQ positions starting at the pointer; the first hit wins.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = 0; off < int'(NUM_REQ); off++) begin
      cand = (int'(ptr_i) + off) % int'(NUM_REQ);
      if (!valid_o && req_i[IDX_W'(cand)]) begin
        valid_o             = 1'b1;
        gnt_o[IDX_W'(cand)] = 1'b1;
        idx_o               = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_v3.sv
// Local copy of the common-cells fifo_v3 interface (the subset this block
// uses): synchronous FIFO, registered storage, data_o shows the head entry.
// usage_o wraps to 0 when the FIFO is exactly full, as in the original.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_DEPTH:0]   cnt_q;
  logic                  push_ok, pop_ok;

  assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= (wr_ptr_q == ADDR_DEPTH'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == ADDR_DEPTH'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/dma_issue_arbiter.sv
// Shares one DMA backend and its transfer-ID space between NUM_REQ
// requesters. Round-robin issue stamped with a running ID, in-flight limit
// of MAX_OUTSTANDING, in-order completions routed back via a tracker FIFO.
// Optional feature: define DMA_ARB_PRIO_EN to add prio_i; when any valid
// requester has prio set, arbitration is restricted to that subset (the RR
// pointer is shared between both subsets).
module dma_issue_arbiter
  import dma_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ID_WIDTH        = 16,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
`ifdef DMA_ARB_PRIO_EN
  input  logic [NUM_REQ-1:0]                   prio_i,
`endif
  output logic [NUM_REQ-1:0]                   req_ready_o,
  output logic [ID_WIDTH-1:0]                  req_id_o,
  output logic                                 be_valid_o,
  input  logic                                 be_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]           be_src_o,
  input  logic                                 be_done_i,
  output logic                                 done_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]           done_src_o,
  output logic [ID_WIDTH-1:0]                  done_id_o,
  output logic [ID_WIDTH-1:0]                  next_id_o,
  output logic [ID_WIDTH-1:0]                  completed_id_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 idle_o
);

  localparam int unsigned SRC_W   = $clog2(NUM_REQ);
  localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FIFO_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [SRC_W-1:0]    rr_ptr_q;
  logic [ID_WIDTH-1:0] next_id_q, completed_id_q, done_id_q;
  logic [OUT_W-1:0]    outstanding_q;
  logic                done_valid_q;
  logic [SRC_W-1:0]    done_src_q;

  logic [NUM_REQ-1:0]  eff_req, grant;
  logic [SRC_W-1:0]    grant_idx, fifo_head;
  logic                grant_valid, full, issue, retire;
  logic                fifo_full, fifo_empty;
  logic [FIFO_AW-1:0]  fifo_usage;

`ifdef DMA_ARB_PRIO_EN
  assign eff_req = (|(req_valid_i & prio_i)) ? (req_valid_i & prio_i) : req_valid_i;
`else
  assign eff_req = req_valid_i;
`endif

  dma_arb_rr #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SRC_W)
  ) u_rr (
    .req_i   (eff_req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (grant),
    .idx_o   (grant_idx),
    .valid_o (grant_valid)
  );

  // A retire in the same cycle does not open a slot until the next cycle.
  assign full        = (outstanding_q == OUT_W'(MAX_OUTSTANDING));
  assign be_valid_o  = grant_valid & ~full;
  assign be_src_o    = grant_idx;
  assign issue       = be_valid_o & be_ready_i;
  assign req_ready_o = issue ? grant : '0;
  assign req_id_o    = next_id_q;
  assign retire      = be_done_i & ~fifo_empty;

  fifo_v3 #(
    .DATA_WIDTH (SRC_W),
    .DEPTH      (MAX_OUTSTANDING),
    .ADDR_DEPTH (FIFO_AW)
  ) u_tracker (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage),
    .data_i  (grant_idx),
    .push_i  (issue),
    .data_o  (fifo_head),
    .pop_i   (retire)
  );

  // ID counters, RR pointer, in-flight count and the completion pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q       <= '0;
      next_id_q      <= ID_WIDTH'(1);
      completed_id_q <= ID_WIDTH'(ID_NONE);
      outstanding_q  <= '0;
      done_valid_q   <= 1'b0;
      done_src_q     <= '0;
      done_id_q      <= ID_WIDTH'(ID_NONE);
    end else begin
      done_valid_q <= retire;
      if (issue) begin
        next_id_q <= ID_WIDTH'(next_id(32'(next_id_q), ID_WIDTH));
        rr_ptr_q  <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (retire) begin
        completed_id_q <= ID_WIDTH'(next_id(32'(completed_id_q), ID_WIDTH));
        done_id_q      <= ID_WIDTH'(next_id(32'(completed_id_q), ID_WIDTH));
        done_src_q     <= fifo_head;
      end
      if (issue && !retire) begin
        outstanding_q <= outstanding_q + 1'b1;
      end else if (retire && !issue) begin
        outstanding_q <= outstanding_q - 1'b1;
      end
    end
  end

  assign done_valid_o   = done_valid_q;
  assign done_src_o     = done_src_q;
  assign done_id_o      = done_id_q;
  assign next_id_o      = next_id_q;
  assign completed_id_o = completed_id_q;
  assign outstanding_o  = outstanding_q;
  assign idle_o         = (outstanding_q == '0);

`ifndef SYNTHESIS
  // Completions with nothing in flight are dropped; flag them, and keep the
  // tracker consistent with the in-flight counter.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(be_done_i && fifo_empty))
        else $error("dma_issue_arbiter: be_done_i with no transfer in flight");
      assert (fifo_full == full)
        else $error("dma_issue_arbiter: tracker full flag out of step");
      assert (fifo_full || (fifo_usage == FIFO_AW'(outstanding_q)))
        else $error("dma_issue_arbiter: tracker occupancy out of step");
    end
  end
`endif

endmodule

// File: tb/tb_dma_issue_arbiter.sv
// Bench for dma_issue_arbiter: a 16-bit-ID instance and a 2-bit-ID instance
// share the same stimulus and are compared against a transaction-level model
// (queue of in-flight sources, issue/retire counts, IDs derived arithmetically).
module tb_dma_issue_arbiter;

  localparam int N   = 4;
  localparam int MAX = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [3:0] req_valid;
  logic [3:0] prio;
  logic       be_ready, be_done;

  logic [3:0]  req_ready_m, req_ready_s;
  logic [15:0] req_id_m, done_id_m, next_id_m, completed_id_m;
  logic [1:0]  req_id_s, done_id_s, next_id_s, completed_id_s;
  logic        be_valid_m, be_valid_s, done_valid_m, done_valid_s, idle_m, idle_s;
  logic [1:0]  be_src_m, be_src_s, done_src_m, done_src_s;
  logic [3:0]  outstanding_m, outstanding_s;

  int n_total = 0;
  int n_bad   = 0;

  int     q[$];
  longint issued, retired;
  int     ptr;
  bit     exp_dv;
  int     exp_dsrc;

  always #5 clk_i = ~clk_i;

  dma_issue_arbiter #(.NUM_REQ(N), .ID_WIDTH(16), .MAX_OUTSTANDING(MAX)) u_dut_m (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid),
`ifdef DMA_ARB_PRIO_EN
    .prio_i(prio),
`endif
    .req_ready_o(req_ready_m), .req_id_o(req_id_m), .be_valid_o(be_valid_m),
    .be_ready_i(be_ready), .be_src_o(be_src_m), .be_done_i(be_done),
    .done_valid_o(done_valid_m), .done_src_o(done_src_m), .done_id_o(done_id_m),
    .next_id_o(next_id_m), .completed_id_o(completed_id_m),
    .outstanding_o(outstanding_m), .idle_o(idle_m)
  );

  dma_issue_arbiter #(.NUM_REQ(N), .ID_WIDTH(2), .MAX_OUTSTANDING(MAX)) u_dut_s (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid),
`ifdef DMA_ARB_PRIO_EN
    .prio_i(prio),
`endif
    .req_ready_o(req_ready_s), .req_id_o(req_id_s), .be_valid_o(be_valid_s),
    .be_ready_i(be_ready), .be_src_o(be_src_s), .be_done_i(be_done),
    .done_valid_o(done_valid_s), .done_src_o(done_src_s), .done_id_o(done_id_s),
    .next_id_o(next_id_s), .completed_id_o(completed_id_s),
    .outstanding_o(outstanding_s), .idle_o(idle_s)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // k-th issued ID (k >= 1): IDs cycle through 1 .. 2^w-1.
  function automatic longint id_of(input longint k, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return 1 + ((k - 1) % m);
  endfunction

  function automatic int pick(input logic [3:0] req, input logic [3:0] pr);
    logic [3:0] set;
    set = req;
`ifdef DMA_ARB_PRIO_EN
    if ((req & pr) != 4'b0) set = req & pr;
`else
    if (pr != 4'b0) set = req;
`endif
    for (int off = 0; off < N; off++) begin
      if (set[(ptr + off) % N]) return (ptr + off) % N;
    end
    return -1;
  endfunction

  function automatic longint comp_id(input int w);
    return (retired == 0) ? 0 : id_of(retired, w);
  endfunction

  task automatic model_reset();
    q.delete();
    issued  = 0;
    retired = 0;
    ptr     = 0;
    exp_dv  = 0;
    exp_dsrc = 0;
  endtask

  // One clock: drive at the falling edge, check just after, advance the model.
  task automatic step(input logic [3:0] rq, input logic rdy, input logic dn, input logic [3:0] pr);
    int  g;
    bit  bev, iss, ret;
    logic [3:0] er;
    @(negedge clk_i);
    req_valid = rq;
    be_ready  = rdy;
    be_done   = dn;
    prio      = pr;
    #1;
    g   = pick(rq, pr);
    bev = (g >= 0) && (q.size() < MAX);
    iss = bev && rdy;
    ret = dn && (q.size() > 0);
    er  = iss ? (4'b1 << g) : 4'b0;
    check_val("be_valid_m", 32'(be_valid_m), 32'(bev));
    check_val("be_valid_s", 32'(be_valid_s), 32'(bev));
    if (bev) begin
      check_val("be_src_m", 32'(be_src_m), 32'(g));
      check_val("be_src_s", 32'(be_src_s), 32'(g));
    end
    check_val("req_ready_m", 32'(req_ready_m), 32'(er));
    check_val("req_ready_s", 32'(req_ready_s), 32'(er));
    check_val("req_id_m", 32'(req_id_m), 32'(id_of(issued + 1, 16)));
    check_val("req_id_s", 32'(req_id_s), 32'(id_of(issued + 1, 2)));
    check_val("next_id_m", 32'(next_id_m), 32'(id_of(issued + 1, 16)));
    check_val("next_id_s", 32'(next_id_s), 32'(id_of(issued + 1, 2)));
    check_val("completed_m", 32'(completed_id_m), 32'(comp_id(16)));
    check_val("completed_s", 32'(completed_id_s), 32'(comp_id(2)));
    check_val("outstanding_m", 32'(outstanding_m), 32'(q.size()));
    check_val("outstanding_s", 32'(outstanding_s), 32'(q.size()));
    check_val("idle_m", 32'(idle_m), 32'(q.size() == 0));
    check_val("done_valid_m", 32'(done_valid_m), 32'(exp_dv));
    check_val("done_valid_s", 32'(done_valid_s), 32'(exp_dv));
    if (exp_dv) begin
      check_val("done_src_m", 32'(done_src_m), 32'(exp_dsrc));
      check_val("done_src_s", 32'(done_src_s), 32'(exp_dsrc));
      check_val("done_id_m", 32'(done_id_m), 32'(comp_id(16)));
      check_val("done_id_s", 32'(done_id_s), 32'(comp_id(2)));
    end
    exp_dv = ret;
    if (ret) begin
      exp_dsrc = q.pop_front();
      retired++;
    end
    if (iss) begin
      q.push_back(g);
      issued++;
      ptr = (g + 1) % N;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    req_valid = '0;
    be_ready  = 1'b0;
    be_done   = 1'b0;
    prio      = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    int seq5 [5];
    logic [3:0] rq, pr;
    logic dn;
    seq5 = '{1, 2, 3, 1, 2};
    rst_ni    = 1'b0;
    req_valid = '0;
    be_ready  = 1'b0;
    be_done   = 1'b0;
    prio      = '0;
    model_reset();

    // Reset state
    do_reset();
    #1;
    check_val("t1_next_id", 32'(next_id_m), 32'd1);
    check_val("t1_completed", 32'(completed_id_m), 32'd0);
    check_val("t1_idle", 32'(idle_m), 32'd1);
    check_val("t1_be_valid", 32'(be_valid_m), 32'd0);
    check_val("t1_outstanding", 32'(outstanding_m), 32'd0);
    check_val("t1_done_valid", 32'(done_valid_m), 32'd0);

    // Four requesters held: strict rotation 0..3 with IDs 1..4
    for (int k = 0; k < 4; k++) begin
      step(4'hF, 1'b1, 1'b0, 4'h0);
      check_val("t2_src", 32'(be_src_m), 32'(k));
      check_val("t2_req_id", 32'(req_id_m), 32'(k + 1));
    end
    step(4'h0, 1'b0, 1'b0, 4'h0);
    check_val("t2_outstanding", 32'(outstanding_m), 32'd4);

    // Fill to the limit, retire while full, slot usable next cycle
    do_reset();
    for (int k = 0; k < MAX; k++) step(4'hF, 1'b1, 1'b0, 4'h0);
    step(4'hF, 1'b1, 1'b1, 4'h0);
    check_val("t3_full_bev", 32'(be_valid_m), 32'd0);
    step(4'hF, 1'b1, 1'b0, 4'h0);
    check_val("t3_after_bev", 32'(be_valid_m), 32'd1);
    check_val("t3_done_valid", 32'(done_valid_m), 32'd1);
    check_val("t3_done_src", 32'(done_src_m), 32'd0);
    check_val("t3_done_id", 32'(done_id_m), 32'd1);

    // Issue and retire in the same cycle at three in flight
    do_reset();
    for (int k = 0; k < 3; k++) step(4'hF, 1'b1, 1'b0, 4'h0);
    step(4'hF, 1'b1, 1'b1, 4'h0);
    step(4'h0, 1'b0, 1'b0, 4'h0);
    check_val("t4_outstanding", 32'(outstanding_m), 32'd3);
    check_val("t4_next_id", 32'(next_id_m), 32'd5);
    check_val("t4_completed", 32'(completed_id_m), 32'd1);

    // 2-bit ID space: issue IDs 1,2,3,1,2 and completed never 0 once retired
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(4'h1, 1'b1, (k > 0), 4'h0);
      check_val("t5_req_id", 32'(req_id_s), 32'(seq5[k]));
    end
    for (int k = 0; k < 4; k++) begin
      step(4'h0, 1'b0, (q.size() > 0), 4'h0);
      check_val("t5_cmp_nonzero", 32'(completed_id_s != 2'd0), 32'd1);
    end

`ifdef DMA_ARB_PRIO_EN
    // Priority subset: requester 3 wins every issue until prio drops
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(4'hF, 1'b1, 1'b0, 4'h8);
      check_val("t6_prio_src", 32'(be_src_m), 32'd3);
    end
    step(4'hF, 1'b1, 1'b0, 4'h0);
    check_val("t6_after_src", 32'(be_src_m), 32'd0);
`endif

    // Randomized traffic with a reset in the middle
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      rq = 4'($urandom);
      if ($urandom_range(0, 5) == 0) rq = 4'h0;
`ifdef DMA_ARB_PRIO_EN
      pr = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
`else
      pr = 4'h0;
`endif
      dn = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      step(rq, ($urandom_range(0, 3) != 0), dn, pr);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
